// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, baud divider
// and the default frame-lock timeout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_t;

    localparam int BAUD_DIV        = 434;
    localparam int TIMEOUT_CYC_DEF = 4340;
    localparam int IDX_W           = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request above last_idx, else the lowest one.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic             any,
    output logic [IDX_W-1:0] next_idx
);

    logic             hi_any;
    logic             lo_any;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        // Descending scan leaves the lowest qualifying index in each half.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IDX_W'(i) > last_idx) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(i);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = IDX_W'(i);
                end
            end
        end
        any      = hi_any | lo_any;
        next_idx = hi_any ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Frame-locked round-robin arbiter feeding one UART transmitter; lock timeout under UART_ARB_TIMEOUT_EN.
// Latency: byte accepted in cycle T -> tx_start in T+1; grant one cycle after a request seen in IDLE.
// Backpressure: req_ready only for the owner in SEND; held low while the transmitter is busy.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [IDX_W-1:0]   grant,
    output logic               frame_active,
    output logic               timeout_err
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arb: N_REQ must be 2..8 and TIMEOUT_CYC at least 1");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             frame_active_q, frame_active_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             last_q, last_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             own_valid;
    logic [7:0]       own_data;
    logic             own_last;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req      (req_valid),
        .last_idx (last_grant_q),
        .any      (pick_any),
        .next_idx (pick_idx)
    );

    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        own_last  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                own_valid = req_valid[i];
                own_data  = req_data[8*i +: 8];
                own_last  = req_last[i];
            end
            req_ready[i] = (state_q == SEND) && (grant_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        frame_active_d = frame_active_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        last_d         = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        timeout_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d        = pick_idx;
                    frame_active_d = 1'b1;
                    state_d        = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_d      = '0;
`endif
                end
            end
            SEND: begin
                if (own_valid) begin
                    tx_data_d  = own_data;
                    last_d     = own_last;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_d  = '0;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Owner went quiet too long: drop the lock like a normal release.
                    last_grant_d   = grant_q;
                    frame_active_d = 1'b0;
                    state_d        = IDLE;
                    timeout_err_d  = 1'b1;
                    tmo_cnt_d      = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        last_grant_d   = grant_q;
                        frame_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= IDX_W'(N_REQ - 1);
            frame_active_q <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            last_q         <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            frame_active_q <= frame_active_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            last_q         <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign grant        = grant_q;
    assign frame_active = frame_active_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a frame-level reference model and a busy-flag transmitter model.
module tb_uart_tx_arb;

    localparam int N        = 4;
    localparam int BUSY_LEN = 6;
    localparam int TMO      = 4340;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [2:0]     grant;
    logic           frame_active;
    logic           timeout_err;

    uart_tx_arb dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant        (grant),
        .frame_active (frame_active),
        .timeout_err  (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0]  src_mem [N][16];
    int          head [N];
    int          tail [N];
    logic [N-1:0] acc_vec;
    logic [7:0]  tx_log [$];
    int          grant_log [$];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_expect(input logic [N-1:0] v, input int last);
        logic [N-1:0] vv;
        vv = v;
        for (int k = 1; k <= N; k++) begin
            if (vv[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int r, input logic [7:0] b, input logic l);
        src_mem[r][tail[r] % 16] = {l, b};
        tail[r]++;
    endtask

    // Transmitter model: busy rises the cycle after tx_start, stays high BUSY_LEN cycles.
    initial begin
        int  cnt;
        bit  start_seen;
        cnt = 0;
        start_seen = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (start_seen) begin
                tx_busy = 1'b1;
                cnt = BUSY_LEN;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_busy = 1'b0;
            end
            start_seen = tx_start;
        end
    end

    // Requester driver: presents the head of each source queue, pops on acceptance.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc_vec[i]) head[i]++;
                req_valid[i]      = (head[i] != tail[i]);
                req_data[8*i +: 8] = src_mem[i][head[i] % 16][7:0];
                req_last[i]       = src_mem[i][head[i] % 16][8];
            end
        end
    end

    // Reference model and per-cycle compare, sampled on the falling edge.
    initial begin
        bit           prev_rst, prev_fa, prev_acc, prev_busy, inflight;
        logic [2:0]   prev_grant;
        logic [7:0]   prev_byte;
        logic [N-1:0] prev_valid;
        int           last_model, exp_idx;
        logic [N-1:0] exp_rdy;
        prev_rst = 1'b1; prev_fa = 1'b0; prev_acc = 1'b0; prev_busy = 1'b0; inflight = 1'b0;
        prev_grant = '0; prev_byte = '0; prev_valid = '0; last_model = N - 1;
        acc_vec = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("rst_tx_start", tx_start, 0);
                chk("rst_tx_data", tx_data, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_grant", grant, 0);
                chk("rst_frame_active", frame_active, 0);
                chk("rst_timeout_err", timeout_err, 0);
                last_model = N - 1;
                inflight = 1'b0;
            end else begin
                chk("tx_start_timing", tx_start, prev_acc);
                if (prev_acc) chk("tx_data_byte", tx_data, prev_byte);
                chk("start_while_busy", tx_start & tx_busy, 0);
                chk("ready_at_most_one", $countones(req_ready) <= 1, 1);
                exp_rdy = frame_active ? (N'(1) << grant) : '0;
                if (req_ready != 0) chk("ready_owner_only", req_ready, exp_rdy);
                if (inflight) chk("ready_while_in_flight", req_ready, 0);
                if (frame_active && !prev_fa) begin
                    exp_idx = rr_expect(prev_valid, last_model);
                    chk("grant_had_request", exp_idx >= 0, 1);
                    chk("grant_round_robin", grant, exp_idx);
                    grant_log.push_back(int'(grant));
                end
                if (frame_active && prev_fa) chk("grant_locked", grant, prev_grant);
                if (!frame_active && prev_fa) last_model = int'(prev_grant);
`ifdef UART_ARB_TIMEOUT_EN
                if (timeout_err) chk("timeout_with_release", {prev_fa, frame_active}, 2'b10);
`else
                chk("timeout_err_low", timeout_err, 0);
`endif
                if (tx_start) tx_log.push_back(tx_data);
                if (inflight && prev_busy && !tx_busy) inflight = 1'b0;
            end
            acc_vec  = rst ? '0 : (req_valid & req_ready);
            prev_acc = (acc_vec != 0);
            for (int i = 0; i < N; i++) if (acc_vec[i]) prev_byte = req_data[8*i +: 8];
            if (prev_acc) inflight = 1'b1;
            prev_rst   = rst;
            prev_fa    = frame_active;
            prev_grant = grant;
            prev_valid = req_valid;
            prev_busy  = tx_busy;
        end
    end

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin @(posedge clk); #1; end
        rst = 1'b0;
        tx_log.delete();
        grant_log.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(all_empty() && !frame_active && !tx_busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_idle_reached"}, n < 3000, 1);
    endtask

    task automatic wait_cond(input string name, input int which);
        int n;
        n = 0;
        while (n < 3000) begin
            if (which == 0 && tx_log.size() >= 1) break;
            if (which == 1 && tx_busy) break;
            if (which == 2 && !tx_busy) break;
            if (which == 3 && req_ready[0]) break;
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_wait_bound"}, n < 3000, 1);
    endtask

    task automatic check_logs(input string name, input int n_g, input logic [31:0] g_exp,
                              input int n_t, input logic [63:0] t_exp);
        chk({name, "_grant_count"}, grant_log.size(), n_g);
        for (int k = 0; k < n_g && k < grant_log.size(); k++)
            chk({name, "_grant_order"}, grant_log[k], g_exp[4*k +: 4]);
        chk({name, "_tx_count"}, tx_log.size(), n_t);
        for (int k = 0; k < n_t && k < tx_log.size(); k++)
            chk({name, "_tx_byte"}, tx_log[k], t_exp[8*k +: 8]);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("init_frame_active", frame_active, 0);
        chk("init_tx_data", tx_data, 8'h00);
        chk("init_req_ready", req_ready, 4'b0000);
        do_reset(1);

        // Single one-byte frame from requester 0.
        push(0, 8'h55, 1'b1);
        wait_idle("single");
        check_logs("single", 1, 32'h0, 1, 64'h55);

        // All four request at once: 0,1,2,3 then 0 again.
        do_reset(1);
        push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
        wait_idle("rr4");
        push(0, 8'h20, 1'b1);
        wait_idle("rr4b");
        check_logs("rr4", 5, 32'h0_3210, 5, 64'h20_13_12_11_10);

        // Multi-byte frame of requester 1 while 2 waits.
        do_reset(1);
        push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1); push(2, 8'hB1, 1'b1);
        wait_idle("lock");
        check_logs("lock", 2, 32'h21, 4, 64'hB1_A3_A2_A1);

        // Owner 0 stalls after the first byte of its frame.
        do_reset(1);
        push(0, 8'hC1, 1'b0); push(1, 8'hD1, 1'b1);
        wait_cond("stall_first_byte", 0);
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int n;
            wait_cond("stall_ready", 3);
            n = 0;
            while (!timeout_err && n < TMO + 100) begin @(posedge clk); #1; n++; end
            chk("timeout_cycles", n, TMO);
            chk("timeout_frame_dropped", frame_active, 0);
        end
        wait_idle("stall");
        check_logs("stall", 2, 32'h10, 2, 64'hD1_C1);
`else
        repeat (300) begin @(posedge clk); #1; end
        chk("stall_frame_active", frame_active, 1);
        chk("stall_grant", grant, 0);
        chk("stall_ready_owner", req_ready, 4'b0001);
        chk("stall_tx_count", tx_log.size(), 1);
        push(0, 8'hC2, 1'b1);
        wait_idle("stall");
        check_logs("stall", 2, 32'h10, 3, 64'hD1_C2_C1);
`endif

        // Reset in WAIT_LO abandons the frame; index 0 wins next.
        do_reset(1);
        push(2, 8'hE5, 1'b1);
        wait_cond("mid_busy", 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_frame_active", frame_active, 0);
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_tx_data", tx_data, 8'h00);
        tx_log.delete();
        grant_log.delete();
        wait_cond("midrst_busy_low", 2);
        push(0, 8'h60, 1'b1); push(3, 8'hF3, 1'b1);
        wait_idle("midrst");
        check_logs("midrst", 2, 32'h30, 2, 64'hF3_60);

        // Lone requester re-granted frame after frame.
        do_reset(1);
        push(3, 8'h31, 1'b1); push(3, 8'h32, 1'b1);
        wait_idle("solo");
        check_logs("solo", 2, 32'h33, 2, 64'h32_31);

        repeat (5) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4340, idle cycles before a stalled frame lock is dropped (used only with UART_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  N_REQ  marks the final byte of a requester's frame.
REQ-008 SHALL have port req_ready  output  N_REQ  byte accepted when valid&ready in the same cycle.
REQ-009 SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to the UART transmitter, stable while tx_start is high.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy flag; rises the cycle after tx_start and falls after the stop bit.
REQ-012 SHALL have port grant  output  3  index of the current frame owner, valid while frame_active.
REQ-013 SHALL have port frame_active  output  1  high from grant until release.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse when a lock is dropped by timeout.

Function
REQ-015 SHALL implement states IDLE, SEND, WAIT_HI and WAIT_LO.
REQ-016 IDLE: on any req_valid, SHALL grant round-robin, searching from last_grant+1 and wrapping modulo N_REQ, then enter SEND with frame_active=1.
REQ-017 SEND: req_ready SHALL be asserted combinationally only for the granted index; all other bits SHALL be 0.
REQ-018 SEND: on valid&ready, SHALL latch the byte and req_last and go to WAIT_HI; tx_start SHALL pulse for exactly 1 cycle on the next cycle, with tx_data equal to the accepted byte.
REQ-019 WAIT_HI: SHALL wait for tx_busy=1, then go to WAIT_LO; no further tx_start is issued.
REQ-020 WAIT_LO: on tx_busy=0, if the latched last=1, SHALL release: last_grant<=grant, frame_active<=0, go to IDLE; otherwise SHALL return to SEND with the same owner.
REQ-021 A frame lock SHALL be held across bytes: other requesters are never granted mid-frame, even if the owner deasserts valid.
REQ-022 Latency: byte accepted in cycle T -> tx_start in cycle T+1; the next req_ready of the same owner comes no earlier than 1 cycle after tx_busy falls.
REQ-023 A grant decision and a release SHALL NOT occur in the same cycle; IDLE always lasts at least 1 cycle between frames.
REQ-024 Requests raised by non-owners during a frame SHALL be held pending and arbitrated after release; no request is lost.
REQ-025 A single requester with valid continuously high SHALL be re-granted frame after frame when it is the only requester.

Reset
REQ-026 On rst, SHALL set state=IDLE, tx_start=0, tx_data=0, req_ready=0, grant=0, frame_active=0, timeout_err=0, and last_grant=N_REQ-1 so that index 0 wins first.
REQ-027 rst asserted mid-frame SHALL abandon the frame immediately, with no tx_start in the cycle following reset.

Configuration
REQ-028 With UART_ARB_TIMEOUT_EN defined, SHALL count consecutive SEND cycles with the owner's valid=0; on reaching TIMEOUT_CYC, SHALL release exactly as in REQ-020 and pulse timeout_err; the counter SHALL clear on every accepted byte.
REQ-029 Without UART_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied to 0, and the lock SHALL be held indefinitely.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state encoding, the baud divider constant BAUD_DIV=434, and the default TIMEOUT_CYC.
REQ-031 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, last index; outputs: any, next index), purely combinational.

Verification
REQ-032 Reset then req_valid=0001 with a single byte 0x55 and last=1 -> grant=0, tx_start one pulse with tx_data=0x55, release after tx_busy falls.
REQ-033 All 4 valid, each sending a 1-byte frame -> grant order 0,1,2,3, then 0 again on re-request.
REQ-034 Owner 1 sends a 3-byte frame A1,A2,A3 while 2 is valid -> bytes A1,A2,A3 go out contiguously, then grant=2.
REQ-035 Owner 0 drops valid after byte 1 of 2 -> frame_active stays 1 and no grant to others; with the macro, timeout_err pulses after 4340 cycles and grant moves on.
REQ-036 rst pulsed in WAIT_LO -> all outputs return to reset values next cycle; the next grant is index 0.
REQ-037 Bench SHALL check that tx_start never fires while tx_busy=1 and that no more than one req_ready bit is high in any cycle.
